data_sram_bridge: RTL
=====================

// Module: data_sram_bridge
// PURPOSE
//  Memory-stage load/store unit between the pipelined datapath (M-stage outputs) and an
//  SRAM-like data bus with address/data handshakes. Turns one M-stage access into one bus
//  transaction, generating byte strobes, replicated store data and aligned, extended load data.
//  Holds the pipeline via stall_m while a transaction is outstanding.
// PARAMETERS
//  ADDR_W   32  bus/datapath address width
//  TIMEOUT  0   max cycles in REQ+WAIT before forced abort with bus_err; 0 = watchdog disabled
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous, active-low reset
//  mem_en       in   1       M stage holds a load/store this cycle
//  mem_wr       in   1       1 = store, 0 = load
//  mem_size     in   2       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  mem_sext     in   1       loads: 1 sign-extend, 0 zero-extend
//  mem_addr     in   ADDR_W  byte address (aluoutM)
//  mem_wdata    in   32      store data (writedataM), value in low bits
//  stall_other  in   1       another stall source is holding the M stage
//  stall_m      out  1       hold F..M stages
//  rdata_m      out  32      aligned/extended load data, valid in DONE
//  addr_err     out  1       misaligned access detected, no bus request issued
//  bus_err      out  1       one-cycle pulse: watchdog expired
//  bus_req      out  1       address phase request
//  bus_wr       out  1       write request
//  bus_size     out  2       00/01/10 as mem_size
//  bus_addr     out  ADDR_W  address, low 2 bits kept as given
//  bus_wstrb    out  4       byte lanes, bit i = bits[8i+7:8i]
//  bus_wdata    out  32      replicated store data
//  bus_addr_ok  in   1       address phase accepted this cycle
//  bus_data_ok  in   1       data phase complete (rdata valid for loads)
//  bus_rdata    in   32      read data
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; bus_req=0, stall_m=0, rdata_m=0, bus_err=0,
//   latched addr/size/sext/wr/wdata=0, watchdog=0. All bus_* outputs come from registers.
//  Alignment (comb.): half with addr[0]=1, or word with addr[1:0]!=0 -> addr_err=mem_en;
//   access dropped, no request, stall_m stays 0.
//  FSM IDLE -> REQ -> WAIT -> DONE -> IDLE:
//   IDLE: mem_en & aligned -> latch request, bus_req=1 next cycle, state REQ; stall_m=1 from
//    the same cycle (comb. on entry condition). Any bus_addr_ok/data_ok in IDLE is ignored.
//   REQ: bus_req=1 and fields stable until bus_addr_ok. addr_ok & data_ok same cycle ->
//    DONE; addr_ok only -> WAIT. bus_req drops the cycle after addr_ok.
//   WAIT: bus_req=0; on bus_data_ok -> DONE, capture result.
//   DONE: stall_m=0, rdata_m valid; stays in DONE while stall_other=1 (no re-issue of the
//    same instruction); returns to IDLE when stall_other=0. Next access starts from IDLE.
//  Minimum latency: 1 stall cycle in REQ + 1 in WAIT unless addr_ok/data_ok arrive sooner.
//  Stores: wstrb byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
//   wdata byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  Loads: lane selected by latched addr[1:0]; byte/half extended per latched mem_sext;
//   rdata_m registered at data_ok and held until next capture. Stores leave rdata_m unchanged.
//  Watchdog (TIMEOUT>0): counts cycles in REQ/WAIT; at count==TIMEOUT -> bus_err pulse,
//   bus_req=0, go DONE, rdata_m=0. Later stray data_ok ignored.
//  Reset mid-transaction: immediate return to IDLE, bus_req=0; no response is reported.
// TESTING
//  1 lw addr 0x100, addr_ok cyc1, data_ok cyc3 rdata 0xDEADBEEF -> stall_m 3 cyc, rdata_m=0xDEADBEEF
//  2 lb sext addr 0x103, rdata 0x80FF_0000 -> rdata_m=0xFFFFFF80; lbu -> 0x00000080
//  3 sh addr 0x102 wdata 0x0000_1234 -> wstrb=1100, wdata=0x12341234, bus_req until addr_ok
//  4 lw addr 0x101 -> addr_err=1, bus_req never asserted, stall_m=0
//  5 addr_ok+data_ok same cycle, stall_other=1 for 2 cyc -> DONE held, exactly one bus_req
//  6 TIMEOUT=4, no addr_ok -> bus_err pulse at cycle 4; rst low mid-WAIT -> IDLE, bus_req=0

Source files
------------

// File: rtl/data_sram_bridge_if.sv
// SRAM-like data bus between the memory-stage bridge (master) and the data memory (slave).
// Address phase: bus_req/bus_addr_ok. Data phase: bus_data_ok, with bus_rdata valid for loads.
interface data_sram_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/data_sram_bridge.sv
// Memory-stage load/store unit: one M-stage access becomes one SRAM-like bus transaction,
// with byte strobes, replicated store data, aligned/extended load data and a pipeline stall.
module data_sram_bridge #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic              mem_sext,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              stall_other,
    output logic              stall_m,
    output logic [31:0]       rdata_m,
    output logic              addr_err,
    output logic              bus_err,
    data_sram_bridge_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateT;

    localparam int WD_W = 16;

    stateT             state;
    stateT             stateNext;
    logic              misaligned;
    logic              startAcc;
    logic              complete;
    logic              timeoutHit;
    logic              wdExpire;
    logic [WD_W-1:0]   wdCnt;

    logic              busReq;
    logic              busWr;
    logic              busErr;
    logic              sextLatched;
    logic [1:0]        busSize;
    logic [ADDR_W-1:0] busAddr;
    logic [3:0]        busWstrb;
    logic [3:0]        strbNext;
    logic [31:0]       busWdata;
    logic [31:0]       wdataNext;
    logic [31:0]       rdataReg;
    logic [15:0]       laneHalf;
    logic [7:0]        laneByte;
    logic [31:0]       loadData;

    // Reserved size 11 is checked and issued as a word access.
    assign misaligned = (mem_size == 2'b01) ? mem_addr[0]
                      : (mem_size[1] ? (mem_addr[1:0] != 2'b00) : 1'b0);
    assign addr_err   = mem_en & misaligned;
    assign wdExpire   = (TIMEOUT != 0) && ((wdCnt + 1'b1) == WD_W'(TIMEOUT));
    assign stall_m    = startAcc || (state == REQ) || (state == WAIT);

    assign bus.bus_req   = busReq;
    assign bus.bus_wr    = busWr;
    assign bus.bus_size  = busSize;
    assign bus.bus_addr  = busAddr;
    assign bus.bus_wstrb = busWstrb;
    assign bus.bus_wdata = busWdata;
    assign rdata_m       = rdataReg;
    assign bus_err       = busErr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A response arriving together with watchdog expiry still counts as a normal completion.
    always_comb begin
        stateNext  = state;
        startAcc   = 1'b0;
        complete   = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (mem_en && !misaligned) begin
                    startAcc  = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (bus.bus_addr_ok && bus.bus_data_ok) begin
                    complete  = 1'b1;
                    stateNext = DONE;
                end else if (wdExpire) begin
                    timeoutHit = 1'b1;
                    stateNext  = DONE;
                end else if (bus.bus_addr_ok) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (bus.bus_data_ok) begin
                    complete  = 1'b1;
                    stateNext = DONE;
                end else if (wdExpire) begin
                    timeoutHit = 1'b1;
                    stateNext  = DONE;
                end
            end
            DONE: begin
                if (!stall_other) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        strbNext  = 4'b1111;
        wdataNext = mem_wdata;
        case (mem_size)
            2'b00: begin
                strbNext  = 4'b0001 << mem_addr[1:0];
                wdataNext = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                strbNext  = 4'b0011 << mem_addr[1:0];
                wdataNext = {2{mem_wdata[15:0]}};
            end
            default: begin
                strbNext  = 4'b1111;
                wdataNext = mem_wdata;
            end
        endcase
    end

    // Load lane selection uses the latched address, so the M stage may change freely in WAIT.
    always_comb begin
        laneHalf = busAddr[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        laneByte = busAddr[0] ? laneHalf[15:8] : laneHalf[7:0];
        case (busSize)
            2'b00:   loadData = {{24{sextLatched & laneByte[7]}}, laneByte};
            2'b01:   loadData = {{16{sextLatched & laneHalf[15]}}, laneHalf};
            default: loadData = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busReq      <= 1'b0;
            busWr       <= 1'b0;
            busSize     <= 2'b00;
            busAddr     <= '0;
            busWstrb    <= 4'b0000;
            busWdata    <= 32'h0;
            sextLatched <= 1'b0;
            rdataReg    <= 32'h0;
            busErr      <= 1'b0;
            wdCnt       <= '0;
        end else begin
            busErr <= timeoutHit;
            if (startAcc) begin
                busReq      <= 1'b1;
                busWr       <= mem_wr;
                busSize     <= (mem_size == 2'b11) ? 2'b10 : mem_size;
                busAddr     <= mem_addr;
                busWstrb    <= strbNext;
                busWdata    <= wdataNext;
                sextLatched <= mem_sext;
            end else if (((state == REQ) && bus.bus_addr_ok) || timeoutHit) begin
                busReq <= 1'b0;
            end

            if (startAcc) begin
                wdCnt <= '0;
            end else if ((state == REQ) || (state == WAIT)) begin
                wdCnt <= wdCnt + 1'b1;
            end

            if (complete && !busWr) begin
                rdataReg <= loadData;
            end else if (timeoutHit) begin
                rdataReg <= 32'h0;
            end
        end
    end

endmodule
